bs_gnrtr_n_rbtr_mm: RTL and testbench
=====================================

Name: bs_gnrtr_n_rbtr_mm

Overview:
- Parametrised next-generation bus generator and arbiter: `drvrs` packet-FIFO drivers share one bus; each packet is routed to one destination or broadcast.
- Sits between the per-driver FIFO interfaces (pndng/pop/D_pop out of each driver FIFO, push/D_push into each receive FIFO) and replaces the fixed-priority single-mode generation.
- Adds a run-time arbitration mode (round-robin or fixed priority), a broadcast ID, invalid-destination dropping, and status counters.

Parameters:
- pckg_sz, 16, packet width in bits; bits [pckg_sz-1 -: 8] hold the destination ID; must be ≥ 9.
- drvrs, 8, number of drivers, 2..16.
- broadcast, 8'hFF, destination ID meaning "deliver to all drivers except the source".
- cnt_w, 16, width of the status counters.

Ports:
- clk, input, 1, single clock; all logic on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- pndng, input, drvrs, bit i high = driver i FIFO non-empty.
- D_pop, input, drvrs*pckg_sz, lane i = head packet of driver i.
- pop, output, drvrs, one-cycle pop strobe to driver i.
- push, output, drvrs, one-cycle push strobe to receiver i.
- D_push, output, pckg_sz, shared delivery data to all receivers.
- arb_mode, input, 1, 0 = round-robin, 1 = fixed priority (lowest index wins).
- busy, output, 1, high whenever the FSM is not in IDLE.
- pkt_cnt, output, cnt_w, packets delivered (unicast or broadcast); saturating.
- drop_cnt, output, cnt_w, packets dropped for invalid destination; saturating.

Behaviour:
- Reset (reset = 0, asynchronous):
  - pop, push, D_push, pkt_cnt, drop_cnt = 0; busy = 0; FSM = IDLE.
  - Round-robin pointer = drvrs-1, so driver 0 wins first.
  - Reset asserted mid-transfer aborts the transfer. No push is issued for the captured packet and no counter changes.
- FSM states IDLE → POP → PUSH → IDLE. One packet per 3 cycles, no pipelining.
- IDLE:
  - If pndng == 0, stay in IDLE.
  - Otherwise choose the winner g; register g and the source index; go to POP.
  - Round-robin winner: first set bit scanning from pointer+1 upward, wrapping modulo drvrs.
  - Fixed-priority winner: lowest set index.
  - arb_mode is sampled in IDLE only; a change during a transfer takes effect at the next arbitration.
- POP (1 cycle):
  - pop[g] = 1; all other pop bits = 0.
  - Capture D_pop lane g into the data register on this edge; go to PUSH.
  - pndng is not rechecked. The driver guarantees its head stays valid while pndng was high at arbitration.
- PUSH (1 cycle):
  - D_push = captured packet; dest = captured[pckg_sz-1 -: 8].
  - dest < drvrs: push[dest] = 1. Self-addressed delivery (dest == g) is allowed; pkt_cnt +1.
  - dest == broadcast: push = all ones except bit g; pkt_cnt +1.
  - Any other dest: push = 0; drop_cnt +1.
  - Round-robin pointer updates to g in this state (both modes update it, so switching to round-robin stays fair); go to IDLE.
- D_push holds its last value outside PUSH. Receivers qualify it with push only.
- pop and push are never high in the same cycle. At most one pop bit is set at any time.
- Counters saturate at 2^cnt_w − 1 and do not wrap.
- busy = 1 in POP and PUSH.
- Starvation bound in round-robin: any continuously pending driver is served within drvrs arbitrations.

Test Plan:
1. Reset, then driver 2 pending with packet 16'h05AB, mode 0 → pop[2] one cycle after pndng is seen; next cycle push = 8'b0010_0000 with D_push = 16'h05AB; pkt_cnt = 1.
2. All 8 drivers continuously pending, mode 0 → grant order 0,1,…,7,0; each pop 3 cycles apart; no driver served twice before all others are served.
3. Drivers 1, 4 and 6 pending, mode 1 → driver 1 served repeatedly while pending. Switch to mode 0 mid-transfer → next winner is 4, then 6.
4. Driver 3 sends 16'hFF12 → push = 8'b1111_0111 for one cycle; pkt_cnt +1.
5. Driver 0 sends dest 8'h09 with drvrs = 8 → pop[0] pulses, push stays 0, drop_cnt = 1, pkt_cnt unchanged.
6. Assert reset low during PUSH → push = 0 immediately (asynchronous), counters reset to 0, busy = 0. After release, round-robin restarts at driver 0.

Source files
------------

// File: rtl/bs_gnrtr_n_rbtr_mm.sv
`default_nettype none
// ============================================================================
// Module   : bs_gnrtr_n_rbtr_mm
// Purpose  : Bus generator and arbiter. `drvrs` packet-FIFO drivers share
//            one delivery bus. Each transfer takes three cycles:
//            IDLE (arbitrate) -> POP (read head) -> PUSH (deliver).
//            The arbitration mode can be changed at run time:
//            round-robin or fixed priority.
//            A packet's destination is either one driver, a broadcast to
//            every driver except the source, or an invalid ID. Invalid
//            packets are dropped.
// Ports    : clk      - rising-edge clock
//            reset    - asynchronous active-low reset
//            pndng    - per-driver FIFO non-empty flags
//            D_pop    - per-driver head packets, lane i = driver i
//            pop      - one-cycle pop strobe to the granted driver
//            push     - one-cycle push strobe(s) to the receivers
//            D_push   - shared delivery data (qualify it with push)
//            arb_mode - 0 = round-robin, 1 = fixed priority (lowest wins)
//            busy     - high while a transfer is in flight
//            pkt_cnt  - delivered packets, saturating
//            drop_cnt - dropped packets, saturating
// Revision : 1.0 - initial release
// ============================================================================
module bs_gnrtr_n_rbtr_mm #(
  parameter int         pckg_sz   = 16,
  parameter int         drvrs     = 8,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int         cnt_w     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push,
  input  logic                     arb_mode,
  output logic                     busy,
  output logic [cnt_w-1:0]         pkt_cnt,
  output logic [cnt_w-1:0]         drop_cnt
);

  localparam int idx_w = (drvrs > 1) ? $clog2(drvrs) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [idx_w-1:0]   grant, rr_ptr;
  logic [idx_w-1:0]   rr_win, fp_win, winner;
  logic [drvrs-1:0]   above_ptr, masked;
  logic [pckg_sz-1:0] data, lane;
  logic [7:0]         dest;
  logic               is_uni, is_bc;

  function automatic logic [idx_w-1:0] lowest_set(input logic [drvrs-1:0] v);
    lowest_set = '0;
    for (int i = drvrs - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = idx_w'(i);
    end
  endfunction

  // Round-robin: the first requester strictly above the pointer wins.
  // If there is none, the scan wraps and the lowest requester wins.
  always_comb begin
    above_ptr = '0;
    for (int i = 0; i < drvrs; i++) begin
      above_ptr[i] = (idx_w'(i) > rr_ptr);
    end
    masked = pndng & above_ptr;
    rr_win = (|masked) ? lowest_set(masked) : lowest_set(pndng);
    fp_win = lowest_set(pndng);
    winner = arb_mode ? fp_win : rr_win;
  end

  // Select the granted driver's head lane. A constant-index mux is used
  // here instead of a variable part-select.
  always_comb begin
    lane = '0;
    for (int i = 0; i < drvrs; i++) begin
      if (grant == idx_w'(i)) lane = D_pop[i*pckg_sz +: pckg_sz];
    end
  end

  assign dest   = data[pckg_sz-1 -: 8];
  assign is_uni = (dest < 8'(drvrs));
  assign is_bc  = !is_uni && (dest == broadcast);
  assign D_push = data;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = '0;
    push      = '0;
    case (state)
      IDLE: if (|pndng) state_nxt = POP;
      POP: begin
        for (int i = 0; i < drvrs; i++) pop[i] = (grant == idx_w'(i));
        state_nxt = PUSH;
      end
      PUSH: begin
        for (int i = 0; i < drvrs; i++) begin
          if (is_uni)     push[i] = (dest == 8'(i));
          else if (is_bc) push[i] = (grant != idx_w'(i));
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant    <= '0;
      rr_ptr   <= idx_w'(drvrs - 1);
      data     <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (|pndng) grant <= winner;
        POP:  data <= lane;
        PUSH: begin
          // The pointer moves in both modes, so switching to round-robin
          // continues fairly from the last served driver.
          rr_ptr <= grant;
          if (is_uni || is_bc) begin
            if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
          end else begin
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bs_gnrtr_n_rbtr_mm.sv
`default_nettype none
// ============================================================================
// Module   : tb_bs_gnrtr_n_rbtr_mm
// Purpose  : Self-checking bench for bs_gnrtr_n_rbtr_mm. The bench holds
//            per-driver packet queues and a transaction-level reference
//            model. Directed scenarios are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bs_gnrtr_n_rbtr_mm;

  localparam int P  = 16;
  localparam int N  = 8;
  localparam int CW = 4;   // narrow counters so saturation is reachable
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  pndng;
  logic [N*P-1:0] D_pop;
  logic [N-1:0]  pop, push;
  logic [P-1:0]  D_push;
  logic          arb_mode;
  logic          busy;
  logic [CW-1:0] pkt_cnt, drop_cnt;

  bs_gnrtr_n_rbtr_mm #(.pckg_sz(P), .drvrs(N), .broadcast(8'hFF), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .arb_mode(arb_mode), .busy(busy),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  logic [P-1:0] q [N][$];
  int checks = 0, errors = 0, cyc = 0;

  // reference model: transfer phase (0 idle, 1 popping, 2 pushing)
  int m_phase, m_g, m_ptr, m_pkt_cnt, m_drop_cnt;
  logic [P-1:0] m_pkt, m_dpush;

  int pop_log[$], pop_cyc[$], push_cyc[$];
  logic [N-1:0] push_log[$];
  logic [P-1:0] push_data[$];
  bit rm_armed, pop_seen;
  int rm_idx, pop_seen_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [N-1:0] p);
    for (int k = 1; k <= N; k++) if (p[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  function automatic int fp_pick(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[i]) return i;
    return 0;
  endfunction

  function automatic logic [N-1:0] exp_push_of(input logic [P-1:0] pkt, input int g);
    logic [N-1:0] one;
    int d;
    one = 1;
    d = int'(pkt[P-1 -: 8]);
    if (d < N) return one << d;
    if (d == 255) return ~(one << g);
    return '0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_g = 0; m_ptr = N - 1;
    m_pkt_cnt = 0; m_drop_cnt = 0; m_pkt = '0; m_dpush = '0;
  endtask

  task automatic drive_and_step();
    int d;
    if (rm_armed) begin
      if (q[rm_idx].size() > 0) void'(q[rm_idx].pop_front());
      rm_armed = 0;
    end
    if (pop_seen) begin
      rm_armed = 1; rm_idx = pop_seen_idx; pop_seen = 0;
    end
    for (int i = 0; i < N; i++) begin
      pndng[i] = (q[i].size() > 0);
      D_pop[i*P +: P] = (q[i].size() > 0) ? q[i][0] : '0;
    end
    if (!reset) begin
      model_reset();
      rm_armed = 0; pop_seen = 0;
    end else begin
      case (m_phase)
        0: if (pndng != 0) begin
             m_g = arb_mode ? fp_pick(pndng) : rr_pick(m_ptr, pndng);
             m_phase = 1;
           end
        1: begin
             m_pkt = D_pop[m_g*P +: P];
             m_dpush = m_pkt;
             m_phase = 2;
           end
        default: begin
             d = int'(m_pkt[P-1 -: 8]);
             if (d < N || d == 255) begin
               if (m_pkt_cnt < CMAX) m_pkt_cnt++;
             end else begin
               if (m_drop_cnt < CMAX) m_drop_cnt++;
             end
             m_ptr = m_g;
             m_phase = 0;
           end
      endcase
    end
  endtask

  task automatic compare();
    logic [N-1:0] one, ep, eu;
    one = 1;
    ep = (m_phase == 1) ? (one << m_g) : '0;
    eu = (m_phase == 2) ? exp_push_of(m_pkt, m_g) : '0;
    chk("pop", 32'(pop), 32'(ep));
    chk("push", 32'(push), 32'(eu));
    chk("D_push", 32'(D_push), 32'(m_dpush));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt_cnt));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop_cnt));
    if (pop != 0) begin
      for (int i = 0; i < N; i++) if (pop[i]) pop_seen_idx = i;
      pop_seen = 1;
      pop_log.push_back(pop_seen_idx);
      pop_cyc.push_back(cyc);
    end
    if (push != 0) begin
      push_log.push_back(push);
      push_data.push_back(D_push);
      push_cyc.push_back(cyc);
    end
  endtask

  task automatic cycle();
    drive_and_step();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  function automatic bit any_queued();
    for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1;
    return 0;
  endfunction

  task automatic drain(input int max);
    int n = 0;
    while ((any_queued() || m_phase != 0 || rm_armed || pop_seen) && n < max) begin
      cycle();
      n++;
    end
    if (n >= max) begin
      checks++; errors++;
      $display("FAIL drain timeout after %0d cycles", max);
    end
    cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int np, nps, base, n, r, d;
    reset = 1'b0; arb_mode = 1'b0; pndng = '0; D_pop = '0;
    rm_armed = 0; pop_seen = 0; rm_idx = 0; pop_seen_idx = 0;
    model_reset();
    repeat (2) cycle();
    chk("reset pop", 32'(pop), 0);
    chk("reset push", 32'(push), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset D_push", 32'(D_push), 0);
    reset = 1'b1;
    cycle();

    // 1: single unicast from driver 2
    np = pop_log.size(); nps = push_log.size(); base = cyc;
    q[2].push_back(16'h05AB);
    drain(30);
    chk("t1 pop idx", 32'(pop_log[np]), 2);
    chk("t1 pop latency", 32'(pop_cyc[np] - base), 1);
    chk("t1 push latency", 32'(push_cyc[nps] - base), 2);
    chk("t1 push", 32'(push_log[nps]), 32'h20);
    chk("t1 D_push", 32'(push_data[nps]), 32'h05AB);
    chk("t1 pkt_cnt", 32'(pkt_cnt), 1);

    // 2: everyone pending, round-robin from reset
    reset = 1'b0; cycle(); reset = 1'b1;
    np = pop_log.size();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) q[i].push_back({8'((i + 1) % N), 8'(k)});
    drain(200);
    for (int k = 0; k < 9; k++) chk("t2 rr order", 32'(pop_log[np + k]), 32'(k % N));
    for (int k = 0; k < 8; k++) chk("t2 pop spacing", 32'(pop_cyc[np+k+1] - pop_cyc[np+k]), 3);
    chk("t2 saturated pkt_cnt", 32'(pkt_cnt), 32'(CMAX));

    // 3: fixed priority, then switch to round-robin mid-transfer
    arb_mode = 1'b1;
    np = pop_log.size();
    for (int k = 0; k < 5; k++) q[1].push_back({8'd2, 8'(k)});
    q[4].push_back(16'h0344);
    q[6].push_back(16'h0066);
    n = 0;
    while (pop_log.size() < np + 2 && n < 50) begin cycle(); n++; end
    arb_mode = 1'b0;
    drain(200);
    chk("t3 g0", 32'(pop_log[np]), 1);
    chk("t3 g1", 32'(pop_log[np+1]), 1);
    chk("t3 g2", 32'(pop_log[np+2]), 4);
    chk("t3 g3", 32'(pop_log[np+3]), 6);
    chk("t3 g4", 32'(pop_log[np+4]), 1);

    // 4: broadcast from driver 3
    reset = 1'b0; cycle(); reset = 1'b1;
    nps = push_log.size();
    q[3].push_back(16'hFF12);
    drain(30);
    chk("t4 push count", 32'(push_log.size() - nps), 1);
    chk("t4 broadcast push", 32'(push_log[nps]), 32'hF7);
    chk("t4 pkt_cnt", 32'(pkt_cnt), 1);

    // 5: invalid destination is dropped
    np = pop_log.size(); nps = push_log.size();
    q[0].push_back(16'h0934);
    drain(30);
    chk("t5 pop idx", 32'(pop_log[np]), 0);
    chk("t5 no push", 32'(push_log.size() - nps), 0);
    chk("t5 drop_cnt", 32'(drop_cnt), 1);
    chk("t5 pkt_cnt", 32'(pkt_cnt), 1);

    // random traffic
    for (int t = 0; t < 600; t++) begin
      if (t % 25 == 0) arb_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        d = $urandom_range(0, N - 1);
        r = $urandom_range(0, 9);
        if (q[d].size() < 3) begin
          if (r < 6)      q[d].push_back({8'($urandom_range(0, N - 1)), 8'($urandom)});
          else if (r < 8) q[d].push_back({8'hFF, 8'($urandom)});
          else            q[d].push_back({8'($urandom_range(N, 254)), 8'($urandom)});
        end
      end
      cycle();
    end
    drain(300);

    // 6: reset during PUSH
    arb_mode = 1'b0;
    q[5].push_back(16'h0211);
    n = 0;
    while (m_phase != 2 && n < 30) begin cycle(); n++; end
    chk("t6 in PUSH", 32'(push), 32'h04);
    reset = 1'b0;
    #1;
    chk("t6 async push", 32'(push), 0);
    chk("t6 async busy", 32'(busy), 0);
    chk("t6 async pkt_cnt", 32'(pkt_cnt), 0);
    chk("t6 async drop_cnt", 32'(drop_cnt), 0);
    repeat (2) cycle();
    reset = 1'b1;
    np = pop_log.size();
    for (int i = 0; i < 4; i++) q[i].push_back({8'(i + 1), 8'hC0});
    drain(100);
    chk("t6 restart g0", 32'(pop_log[np]), 0);
    chk("t6 restart g1", 32'(pop_log[np+1]), 1);
    chk("t6 pkt_cnt", 32'(pkt_cnt), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
